multiplicador_sequencial8bits: RTL



---
 rtl/multiplicador_sequencial8bits.sv | 139 +++++++++++++
 1 files changed

// File: rtl/multiplicador_sequencial8bits.sv
// ---------------------------------------------------------------------------
// multiplicador_sequencial8bits
// Sequential 8x8 unsigned shift-and-add multiplier for the RPN ALU.
// One iteration per cycle, eight iterations per operation, with a
// start/busy/done handshake towards the RPN control unit.
//
// Ports:
//   Clock    in   1  single clock, rising edge
//   Reset    in   1  synchronous, active-high reset (priority over all inputs)
//   Inicio   in   1  start request, sampled only while Ocupado=0
//   A        in   8  multiplicand, captured on the accepted Inicio
//   B        in   8  multiplier, captured on the accepted Inicio
//   Valor    out  8  registered result byte
//   Overflow out  1  registered flag: product does not fit in 8 bits
//   Ocupado  out  1  high while an operation is in progress (CALCULA, FIM)
//   Pronto   out  1  one-cycle pulse marking a new Valor/Overflow
//
// Build option:
//   MULTIPLICADOR_SATURACAO_INTERNA_EN - when defined, Valor saturates to
//   8'hFF on overflow; otherwise Valor is the raw low byte of the product.
// ---------------------------------------------------------------------------
module multiplicador_sequencial8bits (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Inicio,
  input  logic [7:0] A,
  input  logic [7:0] B,
  output logic [7:0] Valor,
  output logic       Overflow,
  output logic       Ocupado,
  output logic       Pronto
);

  localparam logic [1:0] OCIOSO  = 2'd0;
  localparam logic [1:0] CALCULA = 2'd1;
  localparam logic [1:0] FIM     = 2'd2;

  logic [1:0]  state_r;
  logic [15:0] mcand_r;
  logic [7:0]  mult_r;
  logic [15:0] acc_r;
  logic [2:0]  cnt_r;
  logic [7:0]  valor_r;
  logic        overflow_r;
  logic        ocupado_r;
  logic        pronto_r;
  logic [15:0] produto_s;

  // The product never exceeds 16 bits, so any non-zero upper byte is overflow.
  function automatic logic overflow_de(input logic [15:0] p);
    return |p[15:8];
  endfunction

  // Result byte presented on Valor for a final product.
  function automatic logic [7:0] valor_de(input logic [15:0] p);
`ifdef MULTIPLICADOR_SATURACAO_INTERNA_EN
    if (overflow_de(p)) begin
      return 8'hFF;
    end else begin
      return p[7:0];
    end
`else
    return p[7:0];
`endif
  endfunction

  // Accumulator value after the current iteration (conditional add of the multiplicand).
  always_comb begin
    produto_s = acc_r;
    if (mult_r[0]) begin
      produto_s = acc_r + mcand_r;
    end else begin
      produto_s = acc_r;
    end
  end

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_r    <= OCIOSO;
      mcand_r    <= 16'h0000;
      mult_r     <= 8'h00;
      acc_r      <= 16'h0000;
      cnt_r      <= 3'd0;
      valor_r    <= 8'h00;
      overflow_r <= 1'b0;
      ocupado_r  <= 1'b0;
      pronto_r   <= 1'b0;
    end else begin
      case (state_r)
        OCIOSO: begin
          pronto_r <= 1'b0;
          if (Inicio) begin
            mcand_r   <= {8'h00, A};
            mult_r    <= B;
            acc_r     <= 16'h0000;
            cnt_r     <= 3'd0;
            ocupado_r <= 1'b1;
            state_r   <= CALCULA;
          end else begin
            ocupado_r <= 1'b0;
          end
        end
        CALCULA: begin
          acc_r   <= produto_s;
          mcand_r <= {mcand_r[14:0], 1'b0};
          mult_r  <= {1'b0, mult_r[7:1]};
          cnt_r   <= cnt_r + 3'd1;
          // Last iteration: produto_s already holds the final product.
          if (cnt_r == 3'd7) begin
            valor_r    <= valor_de(produto_s);
            overflow_r <= overflow_de(produto_s);
            pronto_r   <= 1'b1;
            state_r    <= FIM;
          end else begin
            pronto_r   <= 1'b0;
          end
        end
        FIM: begin
          // Inicio is deliberately ignored here; the request is not queued.
          pronto_r  <= 1'b0;
          ocupado_r <= 1'b0;
          state_r   <= OCIOSO;
        end
        default: begin
          pronto_r  <= 1'b0;
          ocupado_r <= 1'b0;
          state_r   <= OCIOSO;
        end
      endcase
    end
  end

  assign Valor    = valor_r;
  assign Overflow = overflow_r;
  assign Ocupado  = ocupado_r;
  assign Pronto   = pronto_r;

endmodule
